// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared opcode constants and FSM state type for the two-client
//            memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  // Request opcode encoding used by both clients and MemDPI
  localparam logic MEM_OP_RD = 1'b0;
  localparam logic MEM_OP_WR = 1'b1;

  // Arbiter FSM: IDLE arbitrates, READ/WRITE own the port for one transaction
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Index of the client that did not win the previous grant
  function automatic logic other_client(input logic idx);
    return ~idx;
  endfunction

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Purpose  : Combinational two-way round-robin pick. A lone requester wins;
//            on a tie the client that was not granted last time wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o,
  output logic       winner_o,
  output logic       any_o
);

  // Pick the winner and produce a one-hot grant vector
  always_comb begin
    any_o    = |valid_i;
    winner_o = 1'b0;
    grant_o  = 2'b00;
    if (&valid_i) begin
      winner_o = other_client(last_grant_i);
    end else begin
      winner_o = valid_i[1];
    end
    if (any_o) begin
      grant_o = winner_o ? 2'b10 : 2'b01;
    end
  end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one MemDPI port between two clients. Whole transactions
//            are granted round-robin from IDLE; beats are then routed between
//            the owning client and MemDPI until len+1 beats have moved.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 32,
  parameter int MEM_DATA_BITS = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  // client 0
  input  logic                     c0_req_valid,
  input  logic                     c0_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  c0_req_len,
  input  logic [MEM_ADDR_BITS-1:0] c0_req_addr,
  output logic                     c0_req_ready,
  input  logic                     c0_wr_valid,
  input  logic [MEM_DATA_BITS-1:0] c0_wr_bits,
  output logic                     c0_rd_valid,
  output logic [MEM_DATA_BITS-1:0] c0_rd_bits,
  input  logic                     c0_rd_ready,
  // client 1
  input  logic                     c1_req_valid,
  input  logic                     c1_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  c1_req_len,
  input  logic [MEM_ADDR_BITS-1:0] c1_req_addr,
  output logic                     c1_req_ready,
  input  logic                     c1_wr_valid,
  input  logic [MEM_DATA_BITS-1:0] c1_wr_bits,
  output logic                     c1_rd_valid,
  output logic [MEM_DATA_BITS-1:0] c1_rd_bits,
  input  logic                     c1_rd_ready,
  // MemDPI side
  output logic                     mem_req_valid,
  output logic                     mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]  mem_req_len,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic                     mem_wr_valid,
  output logic [MEM_DATA_BITS-1:0] mem_wr_bits,
  input  logic                     mem_rd_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_rd_bits,
  output logic                     mem_rd_ready
);

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_grant_q, last_grant_d;
  logic [MEM_LEN_BITS-1:0] cnt_q, cnt_d;

  logic [1:0] arb_grant;
  logic       arb_winner;
  logic       arb_any;

  logic                     in_idle;
  logic                     in_read;
  logic                     in_write;
  logic                     own_rd_ready;
  logic                     own_wr_valid;
  logic [MEM_DATA_BITS-1:0] own_wr_bits;
  logic                     beat;

  rr_arb2 u_rr_arb2 (
    .valid_i      ({c1_req_valid, c0_req_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .winner_o     (arb_winner),
    .any_o        (arb_any)
  );

  // State qualifiers; every handshake output is forced low while reset is high
  always_comb begin
    in_idle  = (state_q == IDLE)  && !reset;
    in_read  = (state_q == READ)  && !reset;
    in_write = (state_q == WRITE) && !reset;
  end

  // Select the owning client's beat-side signals
  always_comb begin
    own_rd_ready = owner_q ? c1_rd_ready : c0_rd_ready;
    own_wr_valid = owner_q ? c1_wr_valid : c0_wr_valid;
    own_wr_bits  = owner_q ? c1_wr_bits  : c0_wr_bits;
  end

  // Forward the winning request to MemDPI in the same cycle it is arbitrated
  always_comb begin
    mem_req_valid  = in_idle && arb_any;
    mem_req_opcode = arb_winner ? c1_req_opcode : c0_req_opcode;
    mem_req_len    = arb_winner ? c1_req_len    : c0_req_len;
    mem_req_addr   = arb_winner ? c1_req_addr   : c0_req_addr;
    c0_req_ready   = in_idle && arb_grant[0];
    c1_req_ready   = in_idle && arb_grant[1];
  end

  // Route read beats to the owner only; spurious IDLE beats are not accepted
  always_comb begin
    c0_rd_valid  = in_read && !owner_q && mem_rd_valid;
    c1_rd_valid  = in_read &&  owner_q && mem_rd_valid;
    mem_rd_ready = in_read && own_rd_ready;
    c0_rd_bits   = mem_rd_bits;
    c1_rd_bits   = mem_rd_bits;
  end

  // Route write beats from the owner; non-owner beats are dropped
  always_comb begin
    mem_wr_valid = in_write && own_wr_valid;
    mem_wr_bits  = own_wr_bits;
  end

  // A beat is a read handshake or any forwarded write beat
  always_comb begin
    beat = (in_read && mem_rd_valid && mem_rd_ready) || mem_wr_valid;
  end

  // Next-state: grant in IDLE, count beats down, exit on the final beat
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          owner_d      = arb_winner;
          last_grant_d = arb_winner;
          cnt_d        = mem_req_len;
          state_d      = (mem_req_opcode == MEM_OP_WR) ? WRITE : READ;
        end
      end
      READ, WRITE: begin
        if (beat) begin
          // Exit at zero rather than decrementing, so cnt never wraps
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - MEM_LEN_BITS'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any transfer in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed scenarios followed
//            by a randomized phase, compared cycle by cycle against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        c0_req_valid, c0_req_opcode, c0_req_ready, c0_wr_valid, c0_rd_valid, c0_rd_ready;
  logic [7:0]  c0_req_len;
  logic [31:0] c0_req_addr;
  logic [63:0] c0_wr_bits, c0_rd_bits;
  logic        c1_req_valid, c1_req_opcode, c1_req_ready, c1_wr_valid, c1_rd_valid, c1_rd_ready;
  logic [7:0]  c1_req_len;
  logic [31:0] c1_req_addr;
  logic [63:0] c1_wr_bits, c1_rd_bits;
  logic        mem_req_valid, mem_req_opcode, mem_wr_valid, mem_rd_valid, mem_rd_ready;
  logic [7:0]  mem_req_len;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_wr_bits, mem_rd_bits;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_opcode(c0_req_opcode), .c0_req_len(c0_req_len),
    .c0_req_addr(c0_req_addr), .c0_req_ready(c0_req_ready), .c0_wr_valid(c0_wr_valid),
    .c0_wr_bits(c0_wr_bits), .c0_rd_valid(c0_rd_valid), .c0_rd_bits(c0_rd_bits),
    .c0_rd_ready(c0_rd_ready),
    .c1_req_valid(c1_req_valid), .c1_req_opcode(c1_req_opcode), .c1_req_len(c1_req_len),
    .c1_req_addr(c1_req_addr), .c1_req_ready(c1_req_ready), .c1_wr_valid(c1_wr_valid),
    .c1_wr_bits(c1_wr_bits), .c1_rd_valid(c1_rd_valid), .c1_rd_bits(c1_rd_bits),
    .c1_rd_ready(c1_rd_ready),
    .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode), .mem_req_len(mem_req_len),
    .mem_req_addr(mem_req_addr), .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
    .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: is a transaction open, who owns it, how many beats remain
  bit m_busy  = 1'b0;
  bit m_owner = 1'b0;
  bit m_last  = 1'b1;
  bit m_wr    = 1'b0;
  int m_left  = 0;

  // Observed traffic, for scenario-level checks
  logic [63:0] rdq0[$];
  logic [63:0] rdq1[$];
  logic [63:0] wrq[$];
  bit          grantq[$];
  logic        smp_mem_rd_ready;
  logic        smp_mem_wr_valid;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    rdq0.delete(); rdq1.delete(); wrq.delete(); grantq.delete();
  endtask

  // One clock cycle: predict outputs from current inputs, compare, advance model
  task automatic tick();
    logic        w, e_mreq, e_r0, e_r1, e_rv0, e_rv1, e_mrdy, e_mwv, e_op, beat;
    logic [7:0]  e_len;
    logic [31:0] e_addr;
    logic [63:0] e_wb;
    #1;
    w = 1'b0; e_mreq = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0;
    e_mrdy = 1'b0; e_mwv = 1'b0; e_op = 1'b0; e_len = '0; e_addr = '0; e_wb = '0;
    if (!reset) begin
      if (!m_busy) begin
        if (c0_req_valid || c1_req_valid) begin
          // Lone requester wins; a tie goes to whoever was not served last
          w      = (c0_req_valid && c1_req_valid) ? !m_last : c1_req_valid;
          e_mreq = 1'b1;
          e_r0   = !w;
          e_r1   = w;
          e_op   = w ? c1_req_opcode : c0_req_opcode;
          e_len  = w ? c1_req_len    : c0_req_len;
          e_addr = w ? c1_req_addr   : c0_req_addr;
        end
      end else if (!m_wr) begin
        e_rv0  = !m_owner && mem_rd_valid;
        e_rv1  =  m_owner && mem_rd_valid;
        e_mrdy = m_owner ? c1_rd_ready : c0_rd_ready;
      end else begin
        e_mwv = m_owner ? c1_wr_valid : c0_wr_valid;
        e_wb  = m_owner ? c1_wr_bits  : c0_wr_bits;
      end
    end
    chk("mem_req_valid", mem_req_valid, e_mreq);
    chk("c0_req_ready", c0_req_ready, e_r0);
    chk("c1_req_ready", c1_req_ready, e_r1);
    chk("c0_rd_valid", c0_rd_valid, e_rv0);
    chk("c1_rd_valid", c1_rd_valid, e_rv1);
    chk("mem_rd_ready", mem_rd_ready, e_mrdy);
    chk("mem_wr_valid", mem_wr_valid, e_mwv);
    chk("c0_rd_bits", c0_rd_bits, mem_rd_bits);
    chk("c1_rd_bits", c1_rd_bits, mem_rd_bits);
    if (e_mreq) begin
      chk("mem_req_opcode", mem_req_opcode, e_op);
      chk("mem_req_len", mem_req_len, e_len);
      chk("mem_req_addr", mem_req_addr, e_addr);
    end
    if (e_mwv) chk("mem_wr_bits", mem_wr_bits, e_wb);
    if (c0_rd_valid && c0_rd_ready) rdq0.push_back(c0_rd_bits);
    if (c1_rd_valid && c1_rd_ready) rdq1.push_back(c1_rd_bits);
    if (mem_wr_valid) wrq.push_back(mem_wr_bits);
    if (c0_req_ready) grantq.push_back(1'b0);
    if (c1_req_ready) grantq.push_back(1'b1);
    smp_mem_rd_ready = mem_rd_ready;
    smp_mem_wr_valid = mem_wr_valid;
    @(posedge clock);
    if (reset) begin
      m_busy = 1'b0;
      m_last = 1'b1;
    end else if (!m_busy) begin
      if (e_mreq) begin
        m_busy  = 1'b1;
        m_owner = w;
        m_last  = w;
        m_wr    = e_op;
        m_left  = int'(e_len) + 1;
      end
    end else begin
      beat = m_wr ? e_mwv : (mem_rd_valid && e_mrdy);
      if (beat) begin
        m_left--;
        if (m_left == 0) m_busy = 1'b0;
      end
    end
    #1;
  endtask

  initial begin : main
    bit          pend0, pend1;
    int          gsz, bad;
    logic [63:0] v;
    reset = 1'b1;
    c0_req_valid = 0; c0_req_opcode = 0; c0_req_len = 0; c0_req_addr = 0; c0_wr_valid = 0;
    c0_wr_bits = 0; c0_rd_ready = 0;
    c1_req_valid = 0; c1_req_opcode = 0; c1_req_len = 0; c1_req_addr = 0; c1_wr_valid = 0;
    c1_wr_bits = 0; c1_rd_ready = 0;
    mem_rd_valid = 0; mem_rd_bits = 0;

    // Reset state, with requests and beats present that must be ignored
    c0_req_valid = 1; c1_req_valid = 1; mem_rd_valid = 1; c0_wr_valid = 1;
    tick(); tick();
    c0_req_valid = 0; c1_req_valid = 0; mem_rd_valid = 0; c0_wr_valid = 0;
    reset = 1'b0;

    // Single read: c0, addr 0x100, len 3, four beats A0..A3
    clear_obs();
    c0_req_valid = 1; c0_req_opcode = 0; c0_req_addr = 32'h100; c0_req_len = 8'd3;
    tick();
    c0_req_valid = 0; mem_rd_valid = 1; c0_rd_ready = 1; c1_rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      mem_rd_bits = 64'hA0 + 64'(i);
      tick();
    end
    mem_rd_bits = 64'hEE;
    tick();
    mem_rd_valid = 0; c0_rd_ready = 0; c1_rd_ready = 0;
    chk("rd1_grants", 64'(grantq.size()), 64'd1);
    chk("rd1_beats", 64'(rdq0.size()), 64'd4);
    for (int i = 0; i < rdq0.size(); i++) chk("rd1_data", rdq0[i], 64'hA0 + 64'(i));
    chk("rd1_c1_beats", 64'(rdq1.size()), 64'd0);

    // Single write: c1, addr 0x200, len 1, beats 0x11 and 0x22
    clear_obs();
    c1_req_valid = 1; c1_req_opcode = 1; c1_req_addr = 32'h200; c1_req_len = 8'd1;
    tick();
    c1_req_valid = 0; c1_wr_valid = 1; c1_wr_bits = 64'h11;
    tick();
    c1_wr_bits = 64'h22;
    tick();
    c1_wr_bits = 64'h33;
    tick();
    c1_wr_valid = 0;
    chk("wr1_grants", 64'(grantq.size()), 64'd1);
    if (grantq.size() > 0) chk("wr1_winner", 64'(grantq[0]), 64'd1);
    chk("wr1_beats", 64'(wrq.size()), 64'd2);
    if (wrq.size() >= 2) begin
      chk("wr1_data0", wrq[0], 64'h11);
      chk("wr1_data1", wrq[1], 64'h22);
    end

    // Contention after reset: both held valid, grants must alternate c0,c1,c0,c1
    reset = 1; tick(); reset = 0;
    clear_obs();
    c0_req_valid = 1; c0_req_opcode = 1; c0_req_len = 0; c0_req_addr = 32'h300;
    c1_req_valid = 1; c1_req_opcode = 1; c1_req_len = 0; c1_req_addr = 32'h400;
    c0_wr_valid = 1; c0_wr_bits = 64'hC0; c1_wr_valid = 1; c1_wr_bits = 64'hC1;
    repeat (8) tick();
    c0_req_valid = 0; c1_req_valid = 0; c0_wr_valid = 0; c1_wr_valid = 0;
    tick();
    chk("cont_grants", 64'(grantq.size()), 64'd4);
    for (int i = 0; i < grantq.size(); i++) chk("cont_order", 64'(grantq[i]), 64'(i % 2));
    for (int i = 0; i < wrq.size(); i++) chk("cont_wdata", wrq[i], (i % 2 == 0) ? 64'hC0 : 64'hC1);

    // Read backpressure: c0 len 2, rd_ready low for 3 cycles at the first beat
    clear_obs();
    c0_req_valid = 1; c0_req_opcode = 0; c0_req_len = 8'd2; c0_req_addr = 32'h500;
    tick();
    c0_req_valid = 0; mem_rd_valid = 1;
    for (int i = 0; i < 7; i++) begin
      c0_rd_ready = (i >= 3);
      mem_rd_bits = 64'hB0 + 64'(rdq0.size());
      tick();
      if (i < 3) chk("bp_mem_rd_ready", 64'(smp_mem_rd_ready), 64'd0);
    end
    mem_rd_valid = 0; c0_rd_ready = 0;
    chk("bp_beats", 64'(rdq0.size()), 64'd3);
    for (int i = 0; i < rdq0.size(); i++) chk("bp_data", rdq0[i], 64'hB0 + 64'(i));

    // Reset after 2 of 5 write beats; then a tie must go to c0
    clear_obs();
    c1_req_valid = 1; c1_req_opcode = 1; c1_req_len = 8'd4; c1_req_addr = 32'h600;
    tick();
    c1_req_valid = 0; c1_wr_valid = 1;
    for (int i = 0; i < 2; i++) begin
      c1_wr_bits = 64'hD0 + 64'(i);
      tick();
    end
    reset = 1;
    tick();
    chk("rst_wr_valid_during", 64'(smp_mem_wr_valid), 64'd0);
    reset = 0;
    tick();
    chk("rst_wr_valid_after", 64'(smp_mem_wr_valid), 64'd0);
    c1_wr_valid = 0;
    c0_req_valid = 1; c0_req_opcode = 0; c0_req_len = 0; c0_req_addr = 32'h640;
    c1_req_valid = 1; c1_req_opcode = 0; c1_req_len = 0; c1_req_addr = 32'h680;
    tick();
    c0_req_valid = 0; c1_req_valid = 0; mem_rd_valid = 1; c0_rd_ready = 1;
    tick();
    mem_rd_valid = 0; c0_rd_ready = 0;
    tick();
    chk("rst_wbeats", 64'(wrq.size()), 64'd2);
    chk("rst_grants", 64'(grantq.size()), 64'd2);
    if (grantq.size() >= 2) chk("rst_tie_c0", 64'(grantq[1]), 64'd0);
    chk("rst_c0_beats", 64'(rdq0.size()), 64'd1);

    // Boundary: c1 read len 255 gives 256 beats; c0 write pulses never leak
    clear_obs();
    c1_req_valid = 1; c1_req_opcode = 0; c1_req_len = 8'd255; c1_req_addr = 32'h700;
    tick();
    c1_req_valid = 0; mem_rd_valid = 1; c1_rd_ready = 1;
    for (int i = 0; i < 256; i++) begin
      mem_rd_bits = 64'(i);
      c0_wr_valid = i[0];
      c0_wr_bits  = {$urandom, $urandom};
      tick();
    end
    c0_wr_valid = 1;
    tick();
    c0_wr_valid = 0; mem_rd_valid = 0; c1_rd_ready = 0;
    chk("bnd_beats", 64'(rdq1.size()), 64'd256);
    bad = 0;
    for (int i = 0; i < rdq1.size(); i++) if (rdq1[i] !== 64'(i)) bad++;
    chk("bnd_order", 64'(bad), 64'd0);
    chk("bnd_no_wr_leak", 64'(wrq.size()), 64'd0);
    chk("bnd_c0_rd", 64'(rdq0.size()), 64'd0);

    // Randomized traffic; clients hold request fields until granted
    clear_obs();
    pend0 = 0; pend1 = 0;
    for (int n = 0; n < 600; n++) begin
      if (!pend0 && $urandom_range(0, 2) == 0) begin
        pend0 = 1; c0_req_opcode = 1'($urandom); c0_req_len = 8'($urandom_range(0, 5));
        c0_req_addr = $urandom;
      end
      if (!pend1 && $urandom_range(0, 2) == 0) begin
        pend1 = 1; c1_req_opcode = 1'($urandom); c1_req_len = 8'($urandom_range(0, 5));
        c1_req_addr = $urandom;
      end
      c0_req_valid = pend0; c1_req_valid = pend1;
      c0_wr_valid  = 1'($urandom); c1_wr_valid = 1'($urandom);
      c0_rd_ready  = 1'($urandom); c1_rd_ready = 1'($urandom);
      mem_rd_valid = 1'($urandom);
      v = {$urandom, $urandom}; c0_wr_bits = v;
      v = {$urandom, $urandom}; c1_wr_bits = v;
      v = {$urandom, $urandom}; mem_rd_bits = v;
      reset = ($urandom_range(0, 79) == 0);
      gsz = grantq.size();
      tick();
      if (grantq.size() > gsz) begin
        if (grantq[gsz]) pend1 = 0; else pend0 = 0;
      end
    end
    reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_arbiter

`default_nettype wire
